// File: rtl/relay_protect_fsm_if.sv
// Bus bundle between the relay protection controller and its host:
// sensor samples and operator controls in, relay drive and status out.
interface relay_protect_fsm_if #(
    parameter int N_CH   = 3,
    parameter int DATA_W = 8
);
    logic                     en;
    logic [N_CH*DATA_W-1:0]   sen;
    logic [DATA_W-1:0]        sen_ref;
    logic [DATA_W-1:0]        threshold;
    logic                     clr_latch;
    logic [N_CH-1:0]          relay;
    logic [4*N_CH-1:0]        ch_state;
    logic [N_CH-1:0]          def_fail;
    logic [2:0]               lcd_code;
    logic                     tick;

    modport master (
        output en, sen, sen_ref, threshold, clr_latch,
        input  relay, ch_state, def_fail, lcd_code, tick
    );

    modport slave (
        input  en, sen, sen_ref, threshold, clr_latch,
        output relay, ch_state, def_fail, lcd_code, tick
    );
endinterface

// File: rtl/relay_protect_fsm.sv
// Multi-channel overcurrent relay protection: per-channel debounce, open/reclose
// retry FSM with definitive-fail latch, plus a shared LCD message selector.
module relay_protect_fsm #(
    parameter int N_CH       = 3,
    parameter int DATA_W     = 8,
    parameter int TICK_DIV   = 800000,
    parameter int DEB_TICKS  = 4,
    parameter int OPEN_TICKS = 16,
    parameter int MAX_RETRY  = 3
) (
    input logic               clk,
    input logic               rst,
    relay_protect_fsm_if.slave bus
);
    localparam int TCNT_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DWELL_W = $clog2(OPEN_TICKS + 1);
    localparam int RETRY_W = $clog2(MAX_RETRY + 1);

    localparam logic [TCNT_W-1:0]  TCNT_LAST = TCNT_W'(TICK_DIV - 1);
    localparam logic [2:0]         DEB_MAX   = 3'(DEB_TICKS);
    localparam logic [DWELL_W-1:0] DWELL_MAX = DWELL_W'(OPEN_TICKS);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_MONITOR  = 4'd1,
        ST_SUSPECT  = 4'd2,
        ST_OPEN     = 4'd3,
        ST_CLOSE    = 4'd4,
        ST_DEF_FAIL = 4'd5
    } state_t;

    logic [TCNT_W-1:0]  tcnt;
    logic               tick_now;
    logic [DWELL_W-1:0] hold;
    logic [N_CH-1:0]    recover;
    logic [N_CH-1:0]    is_def;
    logic [N_CH-1:0]    is_act;
    logic [N_CH-1:0]    is_mon;

    always_ff @(posedge clk) begin
        if (!rst)
            tcnt <= '0;
        else if (tcnt == TCNT_LAST)
            tcnt <= '0;
        else
            tcnt <= tcnt + 1'b1;
    end

    assign tick_now = (tcnt == TCNT_LAST);
    assign bus.tick = tick_now;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        state_t             st_q, st_d;
        logic [2:0]         deb_q, deb_d, deb_inc;
        logic [DWELL_W-1:0] dwell_q, dwell_d, dwell_inc;
        logic [RETRY_W-1:0] retry_q, retry_d;
        logic [DATA_W-1:0]  smp;
        logic               over;
        logic               rec;

        assign smp       = bus.sen[i*DATA_W +: DATA_W];
        // Subtraction only matters once smp > sen_ref, so it can never wrap.
        assign over      = (smp > bus.sen_ref) && ((smp - bus.sen_ref) > bus.threshold);
        assign deb_inc   = deb_q + 3'd1;
        assign dwell_inc = dwell_q + 1'b1;

        always_ff @(posedge clk) begin
            if (!rst) begin
                st_q    <= ST_IDLE;
                deb_q   <= '0;
                dwell_q <= '0;
                retry_q <= '0;
            end else begin
                st_q    <= st_d;
                deb_q   <= deb_d;
                dwell_q <= dwell_d;
                retry_q <= retry_d;
            end
        end

        always_comb begin
            st_d    = st_q;
            deb_d   = deb_q;
            dwell_d = dwell_q;
            retry_d = retry_q;
            rec     = 1'b0;
            case (st_q)
                ST_IDLE: begin
                    if (bus.en) st_d = ST_MONITOR;
                end
                ST_MONITOR: begin
                    if (!bus.en) begin
                        st_d = ST_IDLE;
                    end else if (tick_now && over) begin
                        deb_d   = 3'd1;
                        dwell_d = '0;
                        st_d    = (DEB_MAX == 3'd1) ? ST_OPEN : ST_SUSPECT;
                    end
                end
                ST_SUSPECT: begin
                    if (!bus.en) begin
                        st_d  = ST_IDLE;
                        deb_d = '0;
                    end else if (tick_now) begin
                        if (over) begin
                            deb_d = deb_inc;
                            if (deb_inc == DEB_MAX) begin
                                st_d    = ST_OPEN;
                                dwell_d = '0;
                            end
                        end else begin
                            st_d  = ST_MONITOR;
                            deb_d = '0;
                        end
                    end
                end
                ST_OPEN: begin
                    if (tick_now) begin
                        dwell_d = dwell_inc;
                        if (dwell_inc == DWELL_MAX) begin
                            st_d    = ST_CLOSE;
                            retry_d = retry_q + 1'b1;
                            deb_d   = '0;
                        end
                    end
                end
                ST_CLOSE: begin
                    if (tick_now) begin
                        if (over) begin
                            if (retry_q == RETRY_MAX) begin
                                st_d = ST_DEF_FAIL;
                            end else begin
                                st_d    = ST_OPEN;
                                dwell_d = '0;
                            end
                        end else begin
                            deb_d = deb_inc;
                            if (deb_inc == DEB_MAX) begin
                                st_d    = ST_MONITOR;
                                retry_d = '0;
                                rec     = 1'b1;
                            end
                        end
                    end
                end
                ST_DEF_FAIL: begin
                    if (bus.clr_latch) begin
                        st_d    = ST_IDLE;
                        deb_d   = '0;
                        dwell_d = '0;
                        retry_d = '0;
                    end
                end
                default: st_d = ST_IDLE;
            endcase
        end

        assign recover[i]           = rec;
        assign is_def[i]            = (st_q == ST_DEF_FAIL);
        assign is_act[i]            = (st_q == ST_SUSPECT) || (st_q == ST_OPEN) || (st_q == ST_CLOSE);
        assign is_mon[i]            = (st_q == ST_MONITOR);
        assign bus.relay[i]         = (st_q == ST_OPEN) || (st_q == ST_DEF_FAIL);
        assign bus.def_fail[i]      = is_def[i];
        assign bus.ch_state[4*i +: 4] = st_q;
    end

    // A fresh recovery on any channel restarts the "disappeared" message window.
    always_ff @(posedge clk) begin
        if (!rst)
            hold <= '0;
        else if (|recover)
            hold <= DWELL_MAX;
        else if (tick_now && (hold != '0))
            hold <= hold - 1'b1;
    end

    assign bus.lcd_code = (|is_def)      ? 3'd4 :
                          (|is_act)      ? 3'd2 :
                          (hold != '0)   ? 3'd3 :
                          (|is_mon)      ? 3'd1 : 3'd0;
endmodule

// File: tb/tb_relay_protect_fsm.sv
// Randomized and directed bench for relay_protect_fsm against a behavioural
// per-channel model of the protection rules.
module tb_relay_protect_fsm;
    localparam int N_CH = 3, DATA_W = 8, TICK_DIV = 4, DEB_TICKS = 2, OPEN_TICKS = 3, MAX_RETRY = 2;
    localparam int OUT_W = 3 + 12 + 3 + 3 + 1;

    logic clk, rst;
    int n_checks = 0, n_fail = 0;

    relay_protect_fsm_if #(.N_CH(N_CH), .DATA_W(DATA_W)) ifc ();

    relay_protect_fsm #(.N_CH(N_CH), .DATA_W(DATA_W), .TICK_DIV(TICK_DIV), .DEB_TICKS(DEB_TICKS),
                        .OPEN_TICKS(OPEN_TICKS), .MAX_RETRY(MAX_RETRY))
        dut (.clk(clk), .rst(rst), .bus(ifc));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: states as plain integers 0..5, counters as integers.
    int m_st[N_CH], m_deb[N_CH], m_dwell[N_CH], m_retry[N_CH];
    int m_hold, m_cycle;

    task automatic model_step();
        bit tk, rec, ov;
        int s, r, t;
        if (!rst) begin
            for (int c = 0; c < N_CH; c++) begin
                m_st[c] = 0; m_deb[c] = 0; m_dwell[c] = 0; m_retry[c] = 0;
            end
            m_hold = 0; m_cycle = 0;
            return;
        end
        tk  = ((m_cycle % TICK_DIV) == TICK_DIV - 1);
        rec = 0;
        r = int'(ifc.sen_ref); t = int'(ifc.threshold);
        for (int c = 0; c < N_CH; c++) begin
            s  = int'(ifc.sen[c*DATA_W +: DATA_W]);
            ov = (s - r) > t;
            if (m_st[c] == 0) begin
                if (ifc.en) m_st[c] = 1;
            end else if (m_st[c] == 1) begin
                if (!ifc.en) m_st[c] = 0;
                else if (tk && ov) begin
                    m_deb[c] = 1; m_dwell[c] = 0;
                    m_st[c] = (DEB_TICKS == 1) ? 3 : 2;
                end
            end else if (m_st[c] == 2) begin
                if (!ifc.en) begin m_st[c] = 0; m_deb[c] = 0; end
                else if (tk && ov) begin
                    m_deb[c]++;
                    if (m_deb[c] == DEB_TICKS) begin m_st[c] = 3; m_dwell[c] = 0; end
                end else if (tk) begin m_st[c] = 1; m_deb[c] = 0; end
            end else if (m_st[c] == 3) begin
                if (tk) begin
                    m_dwell[c]++;
                    if (m_dwell[c] == OPEN_TICKS) begin m_st[c] = 4; m_retry[c]++; m_deb[c] = 0; end
                end
            end else if (m_st[c] == 4) begin
                if (tk && ov) begin
                    if (m_retry[c] == MAX_RETRY) m_st[c] = 5;
                    else begin m_st[c] = 3; m_dwell[c] = 0; end
                end else if (tk) begin
                    m_deb[c]++;
                    if (m_deb[c] == DEB_TICKS) begin m_st[c] = 1; m_retry[c] = 0; rec = 1; end
                end
            end else if (m_st[c] == 5) begin
                if (ifc.clr_latch) begin
                    m_st[c] = 0; m_deb[c] = 0; m_dwell[c] = 0; m_retry[c] = 0;
                end
            end
        end
        if (rec) m_hold = OPEN_TICKS;
        else if (tk && m_hold > 0) m_hold--;
        m_cycle++;
    endtask

    function automatic logic [OUT_W-1:0] model_out();
        logic [2:0] rl, df, lcd;
        logic [11:0] cs;
        bit any_def = 0, any_act = 0, any_mon = 0;
        for (int c = 0; c < N_CH; c++) begin
            rl[c] = (m_st[c] == 3) || (m_st[c] == 5);
            df[c] = (m_st[c] == 5);
            cs[4*c +: 4] = 4'(m_st[c]);
            if (m_st[c] == 5) any_def = 1;
            if (m_st[c] >= 2 && m_st[c] <= 4) any_act = 1;
            if (m_st[c] == 1) any_mon = 1;
        end
        lcd = any_def ? 3'd4 : any_act ? 3'd2 : (m_hold > 0) ? 3'd3 : any_mon ? 3'd1 : 3'd0;
        return {rl, cs, df, lcd, 1'((m_cycle % TICK_DIV) == TICK_DIV - 1)};
    endfunction

    function automatic logic [OUT_W-1:0] dut_out();
        return {ifc.relay, ifc.ch_state, ifc.def_fail, ifc.lcd_code, ifc.tick};
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_sen(input int s0, input int s1, input int s2);
        ifc.sen = {8'(s2), 8'(s1), 8'(s0)};
    endtask

    task automatic test_reset();
        rst = 1'b0; ifc.en = 1'b0; ifc.clr_latch = 1'b0;
        ifc.sen_ref = 8'd100; ifc.threshold = 8'd10; set_sen(100, 100, 100);
        cycle(); cycle();
        n_checks++;
        if (dut_out() !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got %h expected 0", dut_out());
        end
    endtask

    task automatic test_enable();
        int ticks = 0;
        rst = 1'b1; ifc.en = 1'b1;
        cycle();
        n_checks++;
        if ({ifc.ch_state, ifc.relay, ifc.lcd_code} !== {12'h111, 3'b000, 3'd1}) begin
            n_fail++; $display("FAIL enable_monitor: got st=%h relay=%b lcd=%0d expected st=111 relay=000 lcd=1",
                               ifc.ch_state, ifc.relay, ifc.lcd_code);
        end
        for (int k = 0; k < 4 * TICK_DIV; k++) begin
            cycle();
            if (ifc.tick) ticks++;
            n_checks++;
            if (dut_out() !== model_out()) begin
                n_fail++; $display("FAIL enable_model: got %h expected %h", dut_out(), model_out());
            end
        end
        n_checks++;
        if (ticks != 4) begin
            n_fail++; $display("FAIL tick_rate: got %0d ticks expected 4", ticks);
        end
    endtask

    task automatic test_threshold();
        bit saw_suspect = 0, done = 0;
        set_sen(110, 100, 100);
        for (int k = 0; k < 3 * TICK_DIV; k++) begin
            cycle();
            n_checks++;
            if (dut_out() !== model_out()) begin
                n_fail++; $display("FAIL thresh_equal_model: got %h expected %h", dut_out(), model_out());
            end
        end
        n_checks++;
        if (ifc.ch_state[3:0] !== 4'd1) begin
            n_fail++; $display("FAIL thresh_equal_state: got %0d expected 1", ifc.ch_state[3:0]);
        end
        set_sen(111, 100, 100);
        for (int k = 0; k < 5 * TICK_DIV && !done; k++) begin
            cycle();
            if (ifc.ch_state[3:0] == 4'd2) saw_suspect = 1;
            if (ifc.ch_state[3:0] == 4'd3) done = 1;
            n_checks++;
            if (dut_out() !== model_out()) begin
                n_fail++; $display("FAIL fault_model: got %h expected %h", dut_out(), model_out());
            end
        end
        n_checks++;
        if (!done || !saw_suspect || ifc.relay !== 3'b001 || ifc.lcd_code !== 3'd2) begin
            n_fail++; $display("FAIL fault_open: got done=%0d suspect=%0d relay=%b lcd=%0d expected 1 1 001 2",
                               done, saw_suspect, ifc.relay, ifc.lcd_code);
        end
    endtask

    task automatic test_recovery();
        bit done = 0;
        int n3;
        set_sen(100, 100, 100);
        for (int k = 0; k < 12 * TICK_DIV && !done; k++) begin
            cycle();
            if (ifc.ch_state[3:0] == 4'd1) done = 1;
            n_checks++;
            if (dut_out() !== model_out()) begin
                n_fail++; $display("FAIL recover_model: got %h expected %h", dut_out(), model_out());
            end
        end
        n_checks++;
        if (!done) begin
            n_fail++; $display("FAIL recover_timeout: got state %0d expected 1", ifc.ch_state[3:0]);
        end
        n3 = (ifc.lcd_code == 3'd3) ? 1 : 0;
        for (int k = 0; k < 5 * TICK_DIV; k++) begin
            cycle();
            if (ifc.lcd_code == 3'd3) n3++;
            n_checks++;
            if (dut_out() !== model_out()) begin
                n_fail++; $display("FAIL hold_model: got %h expected %h", dut_out(), model_out());
            end
        end
        n_checks++;
        if (n3 != OPEN_TICKS * TICK_DIV || ifc.lcd_code !== 3'd1) begin
            n_fail++; $display("FAIL hold_window: got %0d cycles lcd_end=%0d expected %0d cycles lcd_end=1",
                               n3, ifc.lcd_code, OPEN_TICKS * TICK_DIV);
        end
    endtask

    task automatic drive_ch1_def_fail(input string name);
        bit done = 0;
        set_sen(100, 200, int'(ifc.sen[23:16]));
        for (int k = 0; k < 40 * TICK_DIV && !done; k++) begin
            cycle();
            if (ifc.def_fail != 3'b000) done = 1;
            n_checks++;
            if (dut_out() !== model_out()) begin
                n_fail++; $display("FAIL %s_model: got %h expected %h", name, dut_out(), model_out());
            end
        end
        n_checks++;
        if (!done || ifc.relay !== 3'b010 || ifc.def_fail !== 3'b010 || ifc.lcd_code !== 3'd4) begin
            n_fail++; $display("FAIL %s_latch: got done=%0d relay=%b def=%b lcd=%0d expected 1 010 010 4",
                               name, done, ifc.relay, ifc.def_fail, ifc.lcd_code);
        end
    endtask

    task automatic test_def_fail();
        drive_ch1_def_fail("deffail");
        for (int k = 0; k < 2 * TICK_DIV; k++) cycle();
        n_checks++;
        if (ifc.ch_state[7:4] !== 4'd5) begin
            n_fail++; $display("FAIL deffail_held: got %0d expected 5", ifc.ch_state[7:4]);
        end
        set_sen(100, 100, 100);
        ifc.clr_latch = 1'b1;
        cycle();
        ifc.clr_latch = 1'b0;
        n_checks++;
        if (ifc.ch_state[7:4] !== 4'd0 || ifc.def_fail !== 3'b000) begin
            n_fail++; $display("FAIL clear_idle: got st=%0d def=%b expected 0 000", ifc.ch_state[7:4], ifc.def_fail);
        end
        cycle();
        n_checks++;
        if (ifc.ch_state[7:4] !== 4'd1) begin
            n_fail++; $display("FAIL clear_monitor: got %0d expected 1", ifc.ch_state[7:4]);
        end
    endtask

    task automatic test_below_ref_and_reset();
        set_sen(100, 100, 50);
        for (int k = 0; k < 8 * TICK_DIV; k++) begin
            cycle();
            n_checks++;
            if (ifc.ch_state[11:8] !== 4'd1) begin
                n_fail++; $display("FAIL below_ref: got %0d expected 1", ifc.ch_state[11:8]);
            end
        end
        drive_ch1_def_fail("reset_mid");
        rst = 1'b0;
        cycle();
        n_checks++;
        if (dut_out() !== '0) begin
            n_fail++; $display("FAIL reset_in_deffail: got %h expected 0", dut_out());
        end
        rst = 1'b1;
    endtask

    task automatic test_random();
        int v[N_CH];
        for (int c = 0; c < N_CH; c++) v[c] = 100;
        for (int k = 0; k < 3000; k++) begin
            for (int c = 0; c < N_CH; c++)
                if ($urandom_range(7) == 0) v[c] = $urandom_range(60, 160);
            set_sen(v[0], v[1], v[2]);
            if ($urandom_range(63) == 0) ifc.en = ~ifc.en;
            ifc.clr_latch = ($urandom_range(15) == 0);
            rst = ($urandom_range(599) != 0);
            if ($urandom_range(399) == 0) begin
                ifc.sen_ref   = 8'($urandom_range(60, 160));
                ifc.threshold = 8'($urandom_range(0, 30));
            end
            cycle();
            n_checks++;
            if (dut_out() !== model_out()) begin
                n_fail++; $display("FAIL random_model: cycle %0d got %h expected %h", k, dut_out(), model_out());
            end
        end
    endtask

    initial begin
        test_reset();
        test_enable();
        test_threshold();
        test_recovery();
        test_def_fail();
        test_below_ref_and_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/relay_protect_fsm.md
RELAY_PROTECT_FSM -- requirements
Module: relay_protect_fsm

Interface
REQ-001 Parameter N_CH, default 3: number of independent sensor/relay channels (1..8).
REQ-002 Parameter DATA_W, default 8: sensor sample width, unsigned.
REQ-003 Parameter TICK_DIV, default 800000: clk cycles per evaluation tick (>=2).
REQ-004 Parameter DEB_TICKS, default 4: consecutive over-threshold ticks that confirm a fault; also the clean ticks that confirm recovery (>=1).
REQ-005 Parameter OPEN_TICKS, default 16: ticks a relay is held open before a reclose attempt (>=1).
REQ-006 Parameter MAX_RETRY, default 3: reclose attempts allowed before definitive fail (>=1).
REQ-007 clk  in  1  sole clock; all logic on its rising edge.
REQ-008 rst  in  1  reset, synchronous, active-low.
REQ-009 en  in  1  global monitoring enable.
REQ-010 sen  in  N_CH*DATA_W  packed samples; channel i at bits [i*DATA_W +: DATA_W].
REQ-011 sen_ref  in  DATA_W  common reference level.
REQ-012 threshold  in  DATA_W  allowed excess over sen_ref.
REQ-013 clr_latch  in  1  operator clear of definitive-fail latches.
REQ-014 relay  out  N_CH  1 = relay i open (load disconnected).
REQ-015 ch_state  out  4*N_CH  state code of channel i at [4*i +: 4].
REQ-016 def_fail  out  N_CH  1 = channel i in DEF_FAIL.
REQ-017 lcd_code  out  3  message selector for LCD driver.
REQ-018 tick  out  1  one-cycle evaluation strobe.

Function
REQ-019 Tick counter counts 0..TICK_DIV-1 and wraps; tick = 1 for exactly the cycle the count equals TICK_DIV-1.
REQ-020 over_i = (sen_i > sen_ref) AND ((sen_i - sen_ref) > threshold), unsigned; sen_i <= sen_ref never flags, no wrap-around underflow.
REQ-021 Each channel has its own FSM, 3-bit debounce counter, retry counter; codes IDLE=0, MONITOR=1, SUSPECT=2, OPEN=3, CLOSE=4, DEF_FAIL=5; codes 6..15 unused, any unused value returns to IDLE next cycle.
REQ-022 Condition evaluation (over_i, counter expiry) happens only on tick cycles; en and clr_latch are acted on every cycle.
REQ-023 IDLE: en=1 -> MONITOR next cycle.
REQ-024 MONITOR: en=0 -> IDLE; tick AND over_i -> SUSPECT with deb=1 (if DEB_TICKS=1 go directly to OPEN).
REQ-025 SUSPECT: en=0 -> IDLE, deb cleared; tick AND over_i -> deb+1, reaching DEB_TICKS -> OPEN, wait=0; tick AND NOT over_i -> MONITOR, deb cleared.
REQ-026 OPEN: en ignored; each tick wait+1; reaching OPEN_TICKS -> CLOSE, retry+1, deb=0.
REQ-027 CLOSE: en ignored; tick AND over_i -> DEF_FAIL if retry = MAX_RETRY else OPEN (wait=0); tick AND NOT over_i -> deb+1, reaching DEB_TICKS -> MONITOR, retry=0.
REQ-028 DEF_FAIL: held until clr_latch=1, then -> IDLE with all channel counters cleared; clr_latch ignored in every other state.
REQ-029 relay_i = 1 in OPEN and DEF_FAIL, 0 otherwise; relay, ch_state, def_fail update on the same edge as the state register (no extra latency).
REQ-030 lcd_code priority: 4 CONTENIDA if any DEF_FAIL; else 2 FALLA if any SUSPECT/OPEN/CLOSE; else 3 DESAPARECIO while recovery hold active; else 1 MEDICION if any MONITOR; else 0 HOLA.
REQ-031 Recovery hold: any CLOSE->MONITOR transition loads a hold counter with OPEN_TICKS; decrements each tick; active while nonzero; reload on new recovery.
REQ-032 Channels are fully independent; simultaneous events on several channels are all processed in the same cycle.

Reset
REQ-033 rst=0 at a rising edge: all channels IDLE, all counters 0, tick counter 0, relay=0, def_fail=0, lcd_code=0, tick=0, regardless of current state (including mid-OPEN or DEF_FAIL).
REQ-034 rst is not sampled asynchronously; outputs hold until the next clk edge with rst=0.

Verification (bench: N_CH=3, DATA_W=8, TICK_DIV=4, DEB_TICKS=2, OPEN_TICKS=3, MAX_RETRY=2; sen_ref=100, threshold=10)
REQ-035 Reset then en=1, all sen=100 -> ch_state all 1 next cycle, relay=000, lcd_code=1; tick every 4th cycle.
REQ-036 sen_0=111 for 2 ticks -> ch0 SUSPECT then OPEN, relay=001, lcd_code=2; sen_0=110 (=threshold) for same time -> stays MONITOR.
REQ-037 ch0 OPEN, sen_0 back to 100 -> CLOSE after 3 ticks, MONITOR after 2 more clean ticks, lcd_code=3 for 3 ticks then 1.
REQ-038 sen_1=200 held -> OPEN/CLOSE cycles twice, DEF_FAIL on second reclose fault, relay=010, def_fail=010, lcd_code=4; clr_latch=1 -> IDLE then MONITOR.
REQ-039 sen_2=50 (below ref) held -> never leaves MONITOR; rst=0 while ch1 in DEF_FAIL -> all outputs 0 next edge.
